// File: rtl/spi_slave.sv
// SPI responder: oversampled SCLK/SS/MOSI deserialised to rx bytes, tx bytes serialised MSB first on MISO.
// Edge-to-action latency 3 clk; rx_valid has no back-pressure, tx bytes are pulled with a tx_ready pulse.
module spi_slave #(
    parameter logic       CPOL      = 1'b0,
    parameter logic       CPHA      = 1'b0,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       SS,
    input  logic       MOSI,
    output logic       MISO,
    output logic       miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       frame_active,
    output logic       tx_underrun
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t      state_q, state_d;
    logic        sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic        ss_s1_q, ss_s2_q, ss_h_q;
    logic        mosi_s1_q, mosi_s2_q;
    logic        armed_q, armed_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        underrun_q, underrun_d;

    logic        sclk_edge, lead_edge, trail_edge;
    logic        ss_fall, ss_rise, in_frame;
    logic        sample_edge, shift_edge;
    logic [7:0]  next_byte;

    assign sclk_edge   = sclk_s2_q ^ sclk_h_q;
    assign lead_edge   = sclk_edge && (sclk_s2_q != CPOL);
    assign trail_edge  = sclk_edge && (sclk_s2_q == CPOL);
    assign ss_fall     = ss_h_q & ~ss_s2_q;
    assign ss_rise     = ~ss_h_q & ss_s2_q;
    // Includes the SS-rise cycle so a final sample edge coinciding with it still completes the byte.
    assign in_frame    = ~(ss_s2_q & ss_h_q);
    assign sample_edge = in_frame & (CPHA ? trail_edge : lead_edge);
    assign shift_edge  = in_frame & (CPHA ? lead_edge : trail_edge);
    assign next_byte   = tx_valid ? tx_data : IDLE_BYTE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sclk_s1_q  <= CPOL;
            sclk_s2_q  <= CPOL;
            sclk_h_q   <= CPOL;
            ss_s1_q    <= 1'b0;
            ss_s2_q    <= 1'b0;
            ss_h_q     <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            armed_q    <= 1'b0;
            cnt_q      <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b1;
            oe_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_s1_q  <= SCLK;
            sclk_s2_q  <= sclk_s1_q;
            sclk_h_q   <= sclk_s2_q;
            ss_s1_q    <= SS;
            ss_s2_q    <= ss_s1_q;
            ss_h_q     <= ss_s2_q;
            mosi_s1_q  <= MOSI;
            mosi_s2_q  <= mosi_s1_q;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        // A frame start is only trusted after SS has been seen high, so a reset mid-frame never rejoins it.
        armed_d    = armed_q | ss_rise;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        miso_d     = miso_q;
        oe_d       = oe_q;
        underrun_d = underrun_q;
        tx_ready   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                oe_d   = 1'b0;
                miso_d = 1'b1;
                cnt_d  = 3'd0;
                if (ss_fall && armed_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                tx_ready   = tx_valid;
                underrun_d = underrun_q | ~tx_valid;
                oe_d       = 1'b1;
                state_d    = S_SHIFT;
                if (CPHA) begin
                    tx_shift_d = next_byte;
                end else begin
                    miso_d     = next_byte[7];
                    tx_shift_d = {next_byte[6:0], 1'b0};
                end
            end
            S_SHIFT: begin
                if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s2_q};
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        if (!ss_rise) begin
                            tx_shift_d = next_byte;
                            tx_ready   = tx_valid;
                            underrun_d = underrun_q | ~tx_valid;
                        end
                    end
                end
                if (shift_edge) begin
                    miso_d     = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (ss_rise) begin
            state_d    = S_IDLE;
            oe_d       = 1'b0;
            miso_d     = 1'b1;
            cnt_d      = 3'd0;
            rx_shift_d = 8'h00;
        end
    end

    assign MISO         = miso_q;
    assign miso_oe      = oe_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign frame_active = armed_q & ~ss_s2_q;
    assign tx_underrun  = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a behavioural master and a tx feeder.
module tb_spi_slave;

    localparam int HALF  = 4;
    localparam int SETUP = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss;
    logic       mosi;
    logic       sclk_m [4];
    logic       miso_m [4];
    logic       oe_m   [4];
    logic       rxv_m  [4];
    logic       txr_m  [4];
    logic       fa_m   [4];
    logic       und_m  [4];
    logic [7:0] rxd_m  [4];
    logic [7:0] tx_data;
    logic       tx_valid;

    int         n_chk = 0;
    int         n_fail = 0;
    int         act_m = 0;
    int         last_evt = 0;
    int         cons_cnt = 0;
    int         tx_base = 0;
    int         tx_n = 0;
    int         tx_idx;
    int         rx_cnt = 0;
    int         rx_base = 0;
    int         bad_chg = 0;
    int         chg_base = 0;
    logic       rdy_seen = 1'b0;
    logic       prev_miso = 1'b1;
    logic       fa_mid;
    logic [7:0] txq    [4];
    logic [7:0] rxq    [8];
    logic [7:0] mbytes [4];
    logic [7:0] mrx    [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .CPOL      (g >= 2),
            .CPHA      ((g % 2) == 1),
            .IDLE_BYTE (8'hFF)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .SCLK         (sclk_m[g]),
            .SS           (ss),
            .MOSI         (mosi),
            .MISO         (miso_m[g]),
            .miso_oe      (oe_m[g]),
            .rx_data      (rxd_m[g]),
            .rx_valid     (rxv_m[g]),
            .tx_data      (tx_data),
            .tx_valid     (tx_valid),
            .tx_ready     (txr_m[g]),
            .frame_active (fa_m[g]),
            .tx_underrun  (und_m[g])
        );
    end

    // tx source: offers txq[0..tx_n-1] in order, advancing once per observed tx_ready pulse
    always_comb begin
        tx_idx   = cons_cnt - tx_base;
        tx_valid = tx_idx < tx_n;
        tx_data  = txq[tx_idx % 4];
    end

    always @(negedge clk) rdy_seen <= txr_m[act_m];
    always @(posedge clk) if (rdy_seen) cons_cnt <= cons_cnt + 1;

    always @(negedge clk) begin
        if (rxv_m[act_m]) begin
            rxq[rx_cnt % 8] <= rxd_m[act_m];
            rx_cnt          <= rx_cnt + 1;
        end
    end

    // MISO may only move after a shift edge (or the SS fall for CPHA=0), never after a sample edge
    always @(negedge clk) begin
        if (ss == 1'b0 && last_evt == 2 && miso_m[act_m] != prev_miso) bad_chg <= bad_chg + 1;
        prev_miso <= miso_m[act_m];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic prep(input int m, input int n);
        act_m    = m;
        tx_base  = cons_cnt;
        tx_n     = n;
        rx_base  = rx_cnt;
        chg_base = bad_chg;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Master: nbits clocked MSB first from mbytes[], MISO captured into mrx[]
    task automatic spi_frame(input int m, input int nbits);
        logic cpol, cpha;
        int   b, bi;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        @(negedge clk);
        ss       = 1'b0;
        last_evt = 0;
        if (!cpha) mosi = mbytes[0][7];
        repeat (SETUP) @(negedge clk);
        fa_mid = fa_m[m];
        for (int k = 0; k < nbits; k++) begin
            b  = k / 8;
            bi = 7 - (k % 8);
            if (cpha) mosi = mbytes[b][bi];
            else      mrx[b][bi] = miso_m[m];
            sclk_m[m] = ~cpol;
            last_evt  = cpha ? 1 : 2;
            repeat (HALF) @(negedge clk);
            if (cpha) mrx[b][bi] = miso_m[m];
            sclk_m[m] = cpol;
            last_evt  = cpha ? 2 : 1;
            if (!cpha && k + 1 < nbits) mosi = mbytes[(k + 1) / 8][7 - ((k + 1) % 8)];
            repeat (HALF) @(negedge clk);
        end
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        ss   = 1'b1;
        mosi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sclk_m[i] = (i >= 2);
            txq[i]    = 8'h00;
            mbytes[i] = 8'h00;
            mrx[i]    = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_miso",     32'(miso_m[0]), 32'd1);
        check("rst_oe",       32'(oe_m[0]),   32'd0);
        check("rst_rx_data",  32'(rxd_m[0]),  32'd0);
        check("rst_rx_valid", 32'(rxv_m[0]),  32'd0);
        check("rst_tx_ready", 32'(txr_m[0]),  32'd0);
        check("rst_frame",    32'(fa_m[0]),   32'd0);
        check("rst_underrun", 32'(und_m[0]),  32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // mode 0 single byte
        txq[0] = 8'h3C; mbytes[0] = 8'hA5;
        prep(0, 1);
        spi_frame(0, 8);
        check("m0_frame_active", 32'(fa_mid),              32'd1);
        check("m0_rx_count",     32'(rx_cnt - rx_base),    32'd1);
        check("m0_rx_data",      32'(rxq[rx_base % 8]),    32'hA5);
        check("m0_miso_byte",    32'(mrx[0]),              32'h3C);
        check("m0_tx_ready_cnt", 32'(cons_cnt - tx_base),  32'd1);
        check("m0_oe_after",     32'(oe_m[0]),             32'd0);
        check("m0_miso_after",   32'(miso_m[0]),           32'd1);
        check("m0_shift_only",   32'(bad_chg - chg_base),  32'd0);

        // underrun
        pulse_rst();
        mbytes[0] = 8'h00;
        prep(0, 0);
        spi_frame(0, 8);
        check("ur_miso_byte", 32'(mrx[0]),   32'hFF);
        check("ur_sticky",    32'(und_m[0]), 32'd1);
        repeat (20) @(negedge clk);
        check("ur_held",      32'(und_m[0]), 32'd1);
        pulse_rst();
        check("ur_cleared",   32'(und_m[0]), 32'd0);

        // three-byte frame
        txq[0] = 8'h11; txq[1] = 8'h22; txq[2] = 8'h33;
        mbytes[0] = 8'h01; mbytes[1] = 8'h80; mbytes[2] = 8'hFF;
        prep(0, 3);
        spi_frame(0, 24);
        check("b3_rx_count", 32'(rx_cnt - rx_base),         32'd3);
        check("b3_rx0",      32'(rxq[rx_base % 8]),         32'h01);
        check("b3_rx1",      32'(rxq[(rx_base + 1) % 8]),   32'h80);
        check("b3_rx2",      32'(rxq[(rx_base + 2) % 8]),   32'hFF);
        check("b3_miso0",    32'(mrx[0]),                   32'h11);
        check("b3_miso1",    32'(mrx[1]),                   32'h22);
        check("b3_miso2",    32'(mrx[2]),                   32'h33);
        check("b3_tx_ready", 32'(cons_cnt - tx_base),       32'd3);

        // partial byte aborted, then realignment
        mbytes[0] = 8'hF0;
        prep(0, 0);
        spi_frame(0, 5);
        check("pa_no_rx",   32'(rx_cnt - rx_base), 32'd0);
        check("pa_oe_gap",  32'(oe_m[0]),          32'd0);
        check("pa_fa_gap",  32'(fa_m[0]),          32'd0);
        mbytes[0] = 8'h5A;
        prep(0, 0);
        spi_frame(0, 8);
        check("pa_rx_count", 32'(rx_cnt - rx_base), 32'd1);
        check("pa_rx_data",  32'(rxq[rx_base % 8]), 32'h5A);

        // reset mid-byte while the master carries on
        mbytes[0] = 8'hFF;
        prep(0, 0);
        fork
            spi_frame(0, 8);
            begin
                repeat (30) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("mr_oe",       32'(oe_m[0]),   32'd0);
                check("mr_miso",     32'(miso_m[0]), 32'd1);
                check("mr_rx_data",  32'(rxd_m[0]),  32'd0);
                check("mr_underrun", 32'(und_m[0]),  32'd0);
                check("mr_frame",    32'(fa_m[0]),   32'd0);
            end
        join
        check("mr_no_rx", 32'(rx_cnt - rx_base), 32'd0);
        mbytes[0] = 8'hC3;
        prep(0, 0);
        spi_frame(0, 8);
        check("mr_rx_count", 32'(rx_cnt - rx_base), 32'd1);
        check("mr_rx_data",  32'(rxq[rx_base % 8]), 32'hC3);

        // modes 1..3
        for (int m = 1; m < 4; m++) begin
            txq[0] = 8'h96; mbytes[0] = 8'h96;
            prep(m, 1);
            spi_frame(m, 8);
            check($sformatf("m%0d_rx_count", m),   32'(rx_cnt - rx_base),  32'd1);
            check($sformatf("m%0d_rx_data", m),    32'(rxq[rx_base % 8]),  32'h96);
            check($sformatf("m%0d_miso_byte", m),  32'(mrx[0]),            32'h96);
            check($sformatf("m%0d_shift_only", m), 32'(bad_chg - chg_base), 32'd0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder: the far-end counterpart of our SPI master driver, for bench loopback and for the sensor-emulation path.
- Oversamples SCLK, SS and MOSI in the system clock domain and deserialises MOSI into bytes.
- Serialises a byte supplied over a valid/ready handshake onto MISO.
- Supports all four SPI modes via parameters; bytes are MSB first.

Parameters:
- CPOL, 0, SCLK idle level (0 = low, 1 = high).
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- IDLE_BYTE, 8'hFF, byte shifted out when no tx byte is available.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- SCLK  in  1  SPI clock from master (asynchronous to clk).
- SS  in  1  slave select, active-low (asynchronous).
- MOSI  in  1  master-out data (asynchronous).
- MISO  out  1  slave-out data.
- miso_oe  out  1  MISO output enable (1 = drive); the top level builds the tristate.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse; rx_data is valid on that cycle.
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  tx_data available.
- tx_ready  out  1  one-cycle pulse; tx_data is consumed on that cycle.
- frame_active  out  1  synchronised SS asserted.
- tx_underrun  out  1  sticky; set when IDLE_BYTE was substituted; cleared by rst only.

Behaviour:
- Reset values: MISO=1, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=0, frame_active=0, tx_underrun=0, bit counter=0, shift registers=0.
- Synchronisers: SCLK, SS and MOSI each pass through 2 flops, plus one history flop for edge detection.
  - Edge detect latency: 3 clk.
  - Constraint: SCLK high and low phases each ≥ 4 clk periods. Faster SCLK is unsupported and need not be detected.
- Edge definitions: leading edge = rising if CPOL=0, falling if CPOL=1; trailing edge is the opposite. Edges count only while synced SS=0.
- State machine:
  - IDLE: miso_oe=0, counter held 0. On synced SS falling edge → LOAD.
  - LOAD (1 cycle):
    - If tx_valid: tx_shift ← tx_data and tx_ready pulses.
    - Else: tx_shift ← IDLE_BYTE and tx_underrun ← 1.
    - miso_oe ← 1.
    - If CPHA=0, MISO ← tx_shift[7] immediately. If CPHA=1, MISO is driven at the first leading edge.
    - → SHIFT.
  - SHIFT:
    - Sample edge: rx_shift ← {rx_shift[6:0], MOSI_sync}; counter increments.
    - Shift edge: next tx bit is placed on MISO.
    - Byte complete: on the 8th sample edge (counter wraps 7→0), rx_data ← the complete byte the cycle after, with rx_valid=1 for exactly one cycle.
    - Next byte: on the same wrap the next tx byte is reloaded (same rules as LOAD, including the tx_ready pulse). CPHA=0 presents its MSB at the following trailing edge. A frame may carry any number of bytes.
  - Synced SS rising edge in any state → IDLE next cycle:
    - miso_oe=0 and MISO=1.
    - Counter reset; a partial byte is discarded with no rx_valid.
    - tx bytes already loaded are not re-offered.
- Simultaneous events:
  - An SS rising edge on the same cycle as the 8th sample edge: the byte completes and rx_valid fires, then the block goes to IDLE.
  - A SCLK edge on the LOAD cycle: the edge is ignored (a master violating the SS-to-SCLK setup time of ≥ 4 clk).
- rst mid-frame: all state returns to reset values. The block stays in IDLE until the next SS falling edge; it does not resynchronise mid-frame.
- rx_valid has no back-pressure. The consumer must take rx_data within 8 SCLK periods, otherwise it is overwritten.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), SCLK = clk/8, master sends 0xA5, tx_data=0x3C with tx_valid=1 → rx_data=0xA5 with one rx_valid pulse; master reads 0x3C; one tx_ready pulse at LOAD.
- tx_valid=0 throughout a 1-byte frame → master reads 0xFF; tx_underrun=1 and stays 1 until rst.
- Back-to-back frame of 3 bytes 0x01, 0x80, 0xFF, with tx bytes 0x11, 0x22, 0x33 presented on each tx_ready → three rx_valid pulses carrying 0x01, 0x80, 0xFF; master reads 0x11, 0x22, 0x33; 3 tx_ready pulses.
- SS deasserted after 5 bits, then a new frame sending 0x5A → no rx_valid for the partial byte; next rx_data=0x5A (bit alignment restored); miso_oe=0 between frames.
- rst asserted for 1 clk mid-byte, master continues, then a new frame sends 0xC3 → outputs return to reset values; no rx_valid until the new frame; the new frame receives 0xC3 correctly.
- Modes 1, 2 and 3 each transfer 0x96 in both directions → rx_data=0x96 and master reads 0x96; MISO changes only on the shift edge for each mode.
